set_number_editor: RTL

Consumes the single-cycle `up`/`down`/`left`/`right` pulses and the toggling `set` level from the button controller, and edits a four-digit BCD MM:SS value for the stopwatch. The block preloads the stopwatch's current time when editing starts, moves a digit cursor, and increments or decrements the selected digit with per-digit wrap. When editing ends, it issues a one-cycle `load` strobe so the stopwatch counter adopts the edited value. The block sits between the button controller and the stopwatch counter/display mux.

---
 rtl/set_number_editor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/set_number_editor.sv
// set_number_editor
//   Edits a four-digit BCD MM:SS value for the stopwatch. Entering edit mode
//   preloads the stopwatch time, with any out-of-range digit cleared to 0.
//   While editing, the cursor moves between digits and the selected digit is
//   incremented or decremented with per-digit wrap and no carry. Leaving edit
//   mode raises a one-cycle load strobe so the counter adopts the new value.
//
//   Optional feature macro: SET_NUMBER_EDITOR_BLINK_EN
//     defined   : the digit under the cursor blinks through `blank`, with a
//                 half-period of BLINK_DIV cycles
//     undefined : `blank` is tied to 4'b0000 and BLINK_DIV is ignored
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-low reset
//   up/down   in   single-cycle pulses: increment/decrement the digit under the cursor
//   left      in   single-cycle pulse: cursor toward the more-significant digit
//   right     in   single-cycle pulse: cursor toward the less-significant digit
//   set       in   level, 1 = edit mode requested
//   cur_value in   current stopwatch time {m10, m1, s10, s1}
//   value     out  edited time {m10, m1, s10, s1}
//   cursor    out  selected digit: 0 = s1, 1 = s10, 2 = m1, 3 = m10
//   editing   out  high while editing
//   load      out  one-cycle commit strobe; value is valid while it is high
//   blank     out  per-digit blank mask for the display
module set_number_editor #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        set,
    input  logic [15:0] cur_value,
    output logic [15:0] value,
    output logic [1:0]  cursor,
    output logic        editing,
    output logic        load,
    output logic [3:0]  blank
);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t state;

    // Units digits go to 9, tens digits to 5; even positions are units.
    function automatic logic [3:0] digit_limit(input logic [1:0] pos);
        return pos[0] ? 4'd5 : 4'd9;
    endfunction

    logic [15:0] sanitized;
    logic [3:0]  digit;
    logic [3:0]  digit_nxt;
    logic [15:0] value_nxt;
    logic [1:0]  cursor_nxt;

    always_comb begin
        sanitized = cur_value;
        for (int unsigned i = 0; i < 4; i++) begin
            if (cur_value[i*4 +: 4] > digit_limit(2'(i)))
                sanitized[i*4 +: 4] = 4'd0;
        end
    end

    // The digit change uses the cursor sampled on this edge, so a
    // simultaneous move only affects the next edit.
    always_comb begin
        digit     = value[{cursor, 2'b00} +: 4];
        digit_nxt = digit;
        if (up && !down)
            digit_nxt = (digit == digit_limit(cursor)) ? 4'd0 : digit + 4'd1;
        else if (down && !up)
            digit_nxt = (digit == 4'd0) ? digit_limit(cursor) : digit - 4'd1;

        value_nxt = value;
        value_nxt[{cursor, 2'b00} +: 4] = digit_nxt;

        cursor_nxt = cursor;
        if (left && !right)
            cursor_nxt = cursor + 2'd1;
        else if (right && !left)
            cursor_nxt = cursor - 2'd1;
    end

`ifdef SET_NUMBER_EDITOR_BLINK_EN
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] blink_cnt_nxt;
    logic          phase;
    logic          phase_nxt;

    always_comb begin
        blink_cnt_nxt = blink_cnt + CW'(1);
        phase_nxt     = phase;
        if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt_nxt = '0;
            phase_nxt     = ~phase;
        end
    end
`else
    // No blink hardware; the parameter only takes part in this empty check.
    if (BLINK_DIV < 2) begin : g_blink_div_unused
    end
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            value   <= '0;
            cursor  <= '0;
            editing <= 1'b0;
            load    <= 1'b0;
`ifdef SET_NUMBER_EDITOR_BLINK_EN
            blank     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    load <= 1'b0;
                    if (set) begin
                        state   <= EDIT;
                        value   <= sanitized;
                        cursor  <= '0;
                        editing <= 1'b1;
`ifdef SET_NUMBER_EDITOR_BLINK_EN
                        blank     <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
`endif
                    end
                end
                EDIT: begin
                    if (!set) begin
                        state   <= COMMIT;
                        editing <= 1'b0;
                        load    <= 1'b1;
`ifdef SET_NUMBER_EDITOR_BLINK_EN
                        blank   <= '0;
`endif
                    end else begin
                        value  <= value_nxt;
                        cursor <= cursor_nxt;
`ifdef SET_NUMBER_EDITOR_BLINK_EN
                        blink_cnt <= blink_cnt_nxt;
                        phase     <= phase_nxt;
                        blank     <= phase_nxt ? (4'b0001 << cursor_nxt) : 4'b0000;
`endif
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    load  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    editing <= 1'b0;
                    load    <= 1'b0;
                end
            endcase
        end
    end

endmodule
